// File: rtl/fod_dsm_ctrl_gen2.sv
// fod_dsm_ctrl_gen2: FOD control word generator.
// A double-buffered FCW drives a MASH1 or MASH1-1 sigma-delta core. The core
// output feeds two aligned pipeline stages that produce the MMD ratio, the
// retimer edge select and the DTC code. SAT is a sticky saturation flag.
// Optional build macro: FOD_DSM_DITHER_EN adds a 15-bit LFSR LSB dither to
// the first-stage accumulator input.
module fod_dsm_ctrl_gen2 #(
  parameter int unsigned WI      = 6,
  parameter int unsigned WF      = 16,
  parameter int unsigned DTC_W   = 10,
  parameter int unsigned KG_W    = 16,
  parameter int unsigned KG_F    = 4,
  parameter int unsigned MMD_MIN = 4,
  parameter int unsigned MMD_MAX = 63
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  input  logic [WI+WF-1:0]    FCW,
  input  logic                MODE,
  input  logic                FCW_VLD,
  output logic                FCW_ACK,
  input  logic [KG_W-1:0]     KDTC,
  output logic [WI-1:0]       MMD_DCW,
  output logic                RT_DCW,
  output logic [DTC_W-1:0]    DTC_DCW,
  output logic                SAT
);

  typedef enum logic {
    MODE_MASH1  = 1'b0,
    MODE_MASH11 = 1'b1
  } dsm_mode_e;

  localparam int unsigned MW = WI + 3;             // signed MMD intermediate
  localparam int unsigned PW = WF + 1 + KG_W + 1;  // DTC product plus rounding

  // Shadow / active control word
  logic [WI+WF-1:0] sh_fcw;
  dsm_mode_e        sh_mode;
  logic             pending;
  logic [WI-1:0]    act_i;
  logic [WF-1:0]    act_f;
  dsm_mode_e        act_mode;
  logic             apply;
  logic             mode_chg;

  // DSM state
  logic [WF-1:0]    acc1;
  logic [WF-1:0]    acc2;
  logic             c2_d;
  logic             dith;

  // DSM combinational results
  logic [WF:0]      s1;
  logic [WF:0]      s2;
  logic             c1;
  logic             c2;
  logic [WF-1:0]    acc1_nx;
  logic [WF-1:0]    acc2_nx;
  logic signed [MW-1:0] mmd_raw;
  logic             mmd_clamp;
  logic [WI-1:0]    mmd_val;
  logic             rt_val;
  logic [WF:0]      rem_val;

  // Stage A registers
  logic [WI-1:0]    mmd_a;
  logic             rt_a;
  logic [WF:0]      rem_a;
  logic             sat_a;

  // Stage B combinational DTC scaling
  logic [PW-1:0]    prod_rnd;
  logic [PW-1:0]    dtc_full;
  logic             dtc_ovf;
  logic [DTC_W-1:0] dtc_code;

  assign apply    = pending & EN;
  assign mode_chg = apply & (sh_mode != act_mode);

`ifdef FOD_DSM_DITHER_EN
  logic [14:0] lfsr;

  // Dither LFSR, x^15 + x^14 + 1, advances with the DSM
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lfsr <= 15'h1;
    end else if (EN) begin
      lfsr <= {lfsr[13:0], lfsr[14] ^ lfsr[13]};
    end
  end

  assign dith = lfsr[14];
`else
  assign dith = 1'b0;
`endif

  // Load handshake: capture into shadow on any edge, apply on an EN edge
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sh_fcw   <= '0;
      sh_mode  <= MODE_MASH1;
      pending  <= 1'b0;
      act_i    <= WI'(MMD_MIN);
      act_f    <= '0;
      act_mode <= MODE_MASH1;
      FCW_ACK  <= 1'b0;
    end else begin
      FCW_ACK <= apply;
      if (apply) begin
        act_i    <= sh_fcw[WI+WF-1:WF];
        act_f    <= sh_fcw[WF-1:0];
        act_mode <= sh_mode;
        pending  <= 1'b0;
      end
      // A new request in the apply cycle becomes the next pending word
      if (FCW_VLD) begin
        sh_fcw  <= FCW;
        sh_mode <= dsm_mode_e'(MODE);
        pending <= 1'b1;
      end
    end
  end

  // DSM core arithmetic and stage-A word formation
  always_comb begin
    s1      = {1'b0, acc1} + {1'b0, act_f} + {{WF{1'b0}}, dith};
    c1      = s1[WF];
    acc1_nx = s1[WF-1:0];
    s2      = {1'b0, acc2} + {1'b0, acc1_nx};
    c2      = s2[WF];
    acc2_nx = s2[WF-1:0];

    mmd_raw = $signed(MW'(act_i)) + $signed(MW'(c1));
    if (act_mode == MODE_MASH11) begin
      mmd_raw = mmd_raw + $signed(MW'(c2)) - $signed(MW'(c2_d)) - $signed(MW'(1));
    end

    mmd_clamp = 1'b0;
    mmd_val   = mmd_raw[WI-1:0];
    if (mmd_raw < $signed(MW'(MMD_MIN))) begin
      mmd_clamp = 1'b1;
      mmd_val   = WI'(MMD_MIN);
    end else if (mmd_raw > $signed(MW'(MMD_MAX))) begin
      mmd_clamp = 1'b1;
      mmd_val   = WI'(MMD_MAX);
    end

    if (act_mode == MODE_MASH11) begin
      // u = acc1_new - c2 + 1.0 lies in [0,2): the integer bit is just ~c2
      rt_val  = 1'b0;
      rem_val = {~c2, acc1_nx};
    end else begin
      // Upper half-period goes to the negedge retimer; DTC covers the rest
      rt_val  = acc1_nx[WF-1];
      rem_val = {2'b00, acc1_nx[WF-2:0]};
    end
  end

  // Accumulators and stage A; a mode change on apply restarts the core
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc1  <= '0;
      acc2  <= '0;
      c2_d  <= 1'b0;
      mmd_a <= WI'(MMD_MIN);
      rt_a  <= 1'b0;
      rem_a <= '0;
      sat_a <= 1'b0;
    end else if (EN) begin
      mmd_a <= mmd_val;
      rt_a  <= rt_val;
      rem_a <= rem_val;
      sat_a <= mmd_clamp;
      if (mode_chg) begin
        acc1 <= '0;
        acc2 <= '0;
        c2_d <= 1'b0;
      end else begin
        acc1 <= acc1_nx;
        if (act_mode == MODE_MASH11) begin
          acc2 <= acc2_nx;
          c2_d <= c2;
        end
      end
    end
  end

  // DTC scaling with round-half-up and saturation
  always_comb begin
    prod_rnd = PW'(rem_a) * PW'(KDTC) + (PW'(1) << (WF + KG_F - 1));
    dtc_full = prod_rnd >> (WF + KG_F);
    dtc_ovf  = |dtc_full[PW-1:DTC_W];
    dtc_code = dtc_ovf ? '1 : dtc_full[DTC_W-1:0];
  end

  // Stage B: aligned output registers and sticky saturation flag
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      MMD_DCW <= WI'(MMD_MIN);
      RT_DCW  <= 1'b0;
      DTC_DCW <= '0;
      SAT     <= 1'b0;
    end else if (EN) begin
      MMD_DCW <= mmd_a;
      RT_DCW  <= rt_a;
      DTC_DCW <= dtc_code;
      SAT     <= SAT | sat_a | dtc_ovf;
    end
  end

endmodule

// File: tb/tb_fod_dsm_ctrl_gen2.sv
// Self-checking bench for fod_dsm_ctrl_gen2 (default build, no dither).
// Expected outputs come from a phase-based arithmetic model of the generator.
module tb_fod_dsm_ctrl_gen2;

  localparam longint ONE  = 64'd65536;  // 1.0 in FCW fraction units
  localparam longint HALF = 64'd32768;

  logic          CLK;
  logic          RST;
  logic          EN;
  logic [21:0]   FCW;
  logic          MODE;
  logic          FCW_VLD;
  logic          FCW_ACK;
  logic [15:0]   KDTC;
  logic [5:0]    MMD_DCW;
  logic          RT_DCW;
  logic [9:0]    DTC_DCW;
  logic          SAT;

  int n_checks = 0;
  int n_fail   = 0;

  fod_dsm_ctrl_gen2 #(
    .WI(6), .WF(16), .DTC_W(10), .KG_W(16), .KG_F(4), .MMD_MIN(4), .MMD_MAX(63)
  ) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .FCW(FCW), .MODE(MODE), .FCW_VLD(FCW_VLD),
    .FCW_ACK(FCW_ACK), .KDTC(KDTC), .MMD_DCW(MMD_DCW), .RT_DCW(RT_DCW),
    .DTC_DCW(DTC_DCW), .SAT(SAT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model state: phases as integers in units of 2^-16
  longint m_ph1, m_ph2;       // first/second integrator phase in [0,1)
  int     m_c2_prev;
  int     m_int;
  longint m_frac;
  int     m_mode;
  longint m_sh_fcw;
  int     m_sh_mode;
  bit     m_pend;
  bit     m_ack;
  int     q_mmd, q_rt;        // word formed by the last step, shown next step
  longint q_rem;
  bit     q_sat;
  int     o_mmd, o_rt, o_dtc;
  bit     o_sat;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph1 = 0; m_ph2 = 0; m_c2_prev = 0;
    m_int = 4; m_frac = 0; m_mode = 0;
    m_sh_fcw = 0; m_sh_mode = 0; m_pend = 0; m_ack = 0;
    q_mmd = 4; q_rt = 0; q_rem = 0; q_sat = 0;
    o_mmd = 4; o_rt = 0; o_dtc = 0; o_sat = 0;
  endtask

  task automatic model_edge(input bit en, input bit vld, input longint fcw,
                            input bit mode, input longint kdtc);
    longint tot1, tot2, phase_err, u, dtc;
    int c1, c2, y, off, mmd, rt;
    bit clamp;
    bit ack_now = 0;
    if (en) begin
      // Output stage shows the previous step's word, scaled by current gain
      dtc = (q_rem * kdtc + (64'd1 << 19)) / (64'd1 << 20);
      o_mmd = q_mmd; o_rt = q_rt;
      o_dtc = (dtc > 1023) ? 1023 : int'(dtc);
      o_sat = o_sat | q_sat | (dtc > 1023);
      // One sigma-delta step
      tot1 = m_ph1 + m_frac;
      c1 = int'(tot1 / ONE);
      tot1 = tot1 % ONE;
      c2 = 0; tot2 = m_ph2;
      if (m_mode == 1) begin
        tot2 = m_ph2 + tot1;
        c2 = int'(tot2 / ONE);
        tot2 = tot2 % ONE;
        y = c1 + c2 - m_c2_prev;
        phase_err = tot1 - c2 * ONE;
        off = 1;
      end else begin
        y = c1;
        phase_err = tot1;
        off = 0;
      end
      u = phase_err + off * ONE;
      mmd = m_int + y - off;
      clamp = (mmd < 4) || (mmd > 63);
      if (mmd < 4) mmd = 4;
      if (mmd > 63) mmd = 63;
      if (m_mode == 1) begin
        rt = 0;
      end else begin
        rt = (u >= HALF) ? 1 : 0;
        u = u - rt * HALF;
      end
      q_mmd = mmd; q_rt = rt; q_rem = u; q_sat = clamp;
      m_ph1 = tot1;
      if (m_mode == 1) begin
        m_ph2 = tot2; m_c2_prev = c2;
      end
      if (m_pend) begin
        if (m_sh_mode != m_mode) begin
          m_ph1 = 0; m_ph2 = 0; m_c2_prev = 0;
        end
        m_int = int'(m_sh_fcw / ONE);
        m_frac = m_sh_fcw % ONE;
        m_mode = m_sh_mode;
        m_pend = 0;
        ack_now = 1;
      end
    end
    if (vld) begin
      m_sh_fcw = fcw; m_sh_mode = mode; m_pend = 1;
    end
    m_ack = ack_now;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".mmd"}, MMD_DCW, o_mmd);
    check_eq({tag, ".rt"},  RT_DCW,  o_rt);
    check_eq({tag, ".dtc"}, DTC_DCW, o_dtc);
    check_eq({tag, ".ack"}, FCW_ACK, m_ack);
    check_eq({tag, ".sat"}, SAT,     o_sat);
  endtask

  // Drive inputs after a negedge, model the posedge, check at the next negedge
  task automatic cycle(input string tag, input bit en, input bit vld,
                       input longint fcw, input bit mode);
    EN = en; FCW_VLD = vld; FCW = 22'(fcw); MODE = mode;
    @(posedge CLK);
    model_edge(en, vld, fcw, mode, longint'(KDTC));
    @(negedge CLK);
    check_outputs(tag);
  endtask

  task automatic do_reset();
    EN = 0; FCW_VLD = 0;
    RST = 1'b1;
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin : stim
    longint fcw_r;
    int ack_cnt;
    bit saw_1023;
    RST = 1'b1; EN = 0; FCW = '0; MODE = 0; FCW_VLD = 0; KDTC = 16'd16000;
    model_reset();
    #1;
    check_outputs("por");
    check_eq("por.mmd_const", MMD_DCW, 4);
    @(negedge CLK);
    RST = 1'b0;

    // MASH1, FCW = 8.25, KDTC = 1000.0
    cycle("m1_load", 0, 1, 8 * ONE + 64'h4000, 0);
    for (int i = 0; i < 14; i++) cycle("m1", 1, 0, 0, 0);

    // Freeze for 5 cycles, then resume
    for (int i = 0; i < 5; i++) cycle("frz", 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle("m1_res", 1, 0, 0, 0);

    // Two loads while frozen: one ACK, second word wins (MASH1-1, 8.5)
    cycle("hs_a", 0, 1, 9 * ONE, 0);
    cycle("hs_b", 0, 1, 8 * ONE + HALF, 1);
    ack_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cycle("hs_run", 1, 0, 0, 0);
      ack_cnt += int'(FCW_ACK);
    end
    check_eq("hs_one_ack", ack_cnt, 1);

    // MASH1-1 at 8.5 for 64 cycles; MMD stays within 6..9
    for (int i = 0; i < 64; i++) begin
      cycle("m11", 1, 0, 0, 0);
      if (i > 2) check_eq("m11_rng", (MMD_DCW >= 6 && MMD_DCW <= 9) ? 1 : 0, 1);
    end

    // Request arriving in the same cycle as an apply
    cycle("co_a", 0, 1, 8 * ONE + HALF, 1);
    cycle("co_b", 1, 1, 7 * ONE + 64'h2000, 1);
    check_eq("co_ack1", FCW_ACK, 1);
    cycle("co_c", 1, 0, 0, 0);
    check_eq("co_ack2", FCW_ACK, 1);
    for (int i = 0; i < 6; i++) cycle("co_run", 1, 0, 0, 0);

    // MMD saturation: 63.9 in MASH1-1
    cycle("sm_load", 1, 1, 63 * ONE + 64'd58982, 1);
    for (int i = 0; i < 12; i++) cycle("sm", 1, 0, 0, 0);
    check_eq("sm_sat", SAT, 1);

    // Async reset while a load is pending: no clock edge needed, no ACK later
    cycle("rp_load", 0, 1, 20 * ONE, 0);
    EN = 0; FCW_VLD = 0;
    #2 RST = 1'b1;
    model_reset();
    #1;
    check_outputs("rst_async");
    check_eq("rst_async.sat", SAT, 0);
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle("rp_run", 1, 0, 0, 0);
      check_eq("rp_noack", FCW_ACK, 0);
    end

    // DTC saturation: KDTC = 0xFFFF at 8.25 in MASH1
    KDTC = 16'hFFFF;
    saw_1023 = 0;
    cycle("sd_load", 1, 1, 8 * ONE + 64'h4000, 0);
    for (int i = 0; i < 10; i++) begin
      cycle("sd", 1, 0, 0, 0);
      if (DTC_DCW == 10'd1023) saw_1023 = 1;
    end
    check_eq("sd_1023", saw_1023, 1);
    check_eq("sd_sat", SAT, 1);

    // Randomized traffic
    do_reset();
    KDTC = 16'(16000);
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 31) == 0) KDTC = 16'($urandom);
      fcw_r = longint'($urandom_range(0, 63)) * ONE + longint'($urandom_range(0, 65535));
      cycle("rnd", ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
            fcw_r, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global bound so the run always terminates
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
